// File: rtl/alu_result_stage_pkg.sv
// Shared opcodes, flag bit positions and result-entry layout for the ALU result stage.
// Latency: none (types and constants only).
// Backpressure: n/a.
package alu_result_stage_pkg;

    typedef enum logic [2:0] {
        OP_SUMA  = 3'b000,
        OP_RESTA = 3'b001,
        OP_MULT  = 3'b010,
        OP_DIV   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_NOR   = 3'b111
    } alu_op_e;

    localparam int OPND_W = 16;
    localparam int RES_W  = 32;
    localparam int FLAG_W = 4;

    // Bit positions inside out_flags = {div0, neg, carry, zero}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_DIV0  = 3;

    // Result reported for any divide by zero, whatever the ALU produced
    localparam logic [RES_W-1:0] DIV0_RESULT = 32'h0000_FFFF;

    // One FIFO entry: flags in the top nibble, result below
    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [RES_W-1:0]  result;
    } result_entry_t;

    localparam int ENTRY_W = $bits(result_entry_t);

    function automatic logic [FLAG_W-1:0] pack_flags(input logic div0,
                                                     input logic neg,
                                                     input logic carry,
                                                     input logic zero);
        logic [FLAG_W-1:0] f;
        f             = '0;
        f[FLAG_DIV0]  = div0;
        f[FLAG_NEG]   = neg;
        f[FLAG_CARRY] = carry;
        f[FLAG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Request, external-ALU and result handshake bundle for alu_result_stage.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on requests, out_valid/out_ready on results.
interface alu_result_stage_if;

    // Request side
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;

    // External ALU: registered operands out, combinational results back
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [16:0] alu_suma;
    logic [15:0] alu_resta;
    logic [31:0] alu_mult;
    logic [15:0] alu_div;
    logic [15:0] alu_and;
    logic [15:0] alu_or;
    logic [15:0] alu_xor;
    logic [15:0] alu_nor;

    // Result side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        err_div0;

    // The stage itself
    modport slave (
        input  in_valid, in_op, in_a, in_b,
        input  alu_suma, alu_resta, alu_mult, alu_div,
        input  alu_and, alu_or, alu_xor, alu_nor,
        input  out_ready,
        output in_ready, alu_a, alu_b,
        output out_valid, out_result, out_flags, err_div0
    );

    // Requester / ALU / consumer environment
    modport master (
        output in_valid, in_op, in_a, in_b,
        output alu_suma, alu_resta, alu_mult, alu_div,
        output alu_and, alu_or, alu_xor, alu_nor,
        output out_ready,
        input  in_ready, alu_a, alu_b,
        input  out_valid, out_result, out_flags, err_div0
    );

endinterface

// File: rtl/alu_result_fifo.sv
// Result FIFO: DEPTH-entry circular buffer feeding a registered head (show-ahead) stage.
// Latency: an entry pushed on edge M is presented at the head after edge M+1.
// Backpressure: head holds while pop_i is low; push is ignored if the buffer is full.
module alu_result_fifo
    import alu_result_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             head_vld_o,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic             head_vld_q, head_vld_d;
    logic [WIDTH-1:0] head_dat_q, head_dat_d;

    logic do_push;
    logic do_pop;
    logic do_load;

    // Guards make push-when-full and pop-when-empty no-ops
    assign do_push = push_i && (mem_cnt_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && head_vld_q;
    // Refill the head whenever it is empty or being consumed this cycle
    assign do_load = (mem_cnt_q != '0) && (!head_vld_q || do_pop);

    // Next-state for pointers, buffer occupancy and the head register
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        head_vld_d = head_vld_q;
        head_dat_d = head_dat_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_load) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            head_vld_d = 1'b1;
            head_dat_d = mem_q[rd_ptr_q];
        end else if (do_pop) begin
            head_vld_d = 1'b0;
        end
        mem_cnt_d = mem_cnt_q + CNT_W'(do_push) - CNT_W'(do_load);
    end

    // Control state; reset empties the FIFO but leaves storage untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            head_vld_q <= 1'b0;
            head_dat_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            head_vld_q <= head_vld_d;
            head_dat_q <= head_dat_d;
        end
    end

    // Storage write; nothing is written on a reset edge
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_vld_o = head_vld_q;
    assign head_dat_o = head_dat_q;
    // Occupancy counts the head register as well as the buffer
    assign count_o    = mem_cnt_q + CNT_W'(head_vld_q);

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: registers operands for an external ALU, then queues the selected result and flags.
// Latency: request accepted on edge N is at out_valid after edge N+2 (FIFO empty); one op in flight at a time.
// Backpressure: in_ready = (queued + in-flight) < DEPTH from registered state; head is held while out_ready is low.
// Build option: ALU_DIV0_TRAP_EN makes err_div0 a sticky divide-by-zero flag; otherwise err_div0 is tied low.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_stage_if.slave bus_if
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic              in_flight_q, in_flight_d;
    alu_op_e           op_q, op_d;
    logic [OPND_W-1:0] alu_a_q, alu_a_d;
    logic [OPND_W-1:0] alu_b_q, alu_b_d;

    logic              accept;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occupancy;
    result_entry_t     push_entry;
    result_entry_t     head_entry;
    logic              head_vld;

    logic [RES_W-1:0]  sel_result;
    logic              sel_neg;
    logic              sel_carry;
    logic              sel_div0;

    // Occupancy uses registered count only, so a same-cycle pop never raises in_ready
    assign occupancy       = {1'b0, fifo_count} + OCC_W'(in_flight_q);
    assign bus_if.in_ready = occupancy < OCC_W'(DEPTH);

    assign accept = bus_if.in_valid && bus_if.in_ready;
    // The in-flight op always completes on the edge after it was accepted
    assign push   = in_flight_q;
    assign pop    = head_vld && bus_if.out_ready;

    // Operand/opcode capture on accept; in-flight follows accept one edge later
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        op_d        = op_q;
        in_flight_d = accept;
        if (accept) begin
            alu_a_d = bus_if.in_a;
            alu_b_d = bus_if.in_b;
            op_d    = alu_op_e'(bus_if.in_op);
        end
    end

    // Operand and in-flight registers; reset drops any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q <= 1'b0;
            op_q        <= OP_SUMA;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            op_q        <= op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
        end
    end

    assign bus_if.alu_a = alu_a_q;
    assign bus_if.alu_b = alu_b_q;

    // Pick the ALU output for the registered opcode and derive neg/carry/div0
    always_comb begin
        sel_result = '0;
        sel_neg    = 1'b0;
        sel_carry  = 1'b0;
        sel_div0   = 1'b0;
        case (op_q)
            OP_SUMA: begin
                sel_result = {15'd0, bus_if.alu_suma};
                sel_carry  = bus_if.alu_suma[16];
            end
            OP_RESTA: begin
                sel_result = {16'd0, bus_if.alu_resta};
                sel_neg    = bus_if.alu_resta[15];
                sel_carry  = alu_a_q < alu_b_q;
            end
            OP_MULT: begin
                sel_result = bus_if.alu_mult;
                sel_neg    = bus_if.alu_mult[31];
            end
            OP_DIV: begin
                if (alu_b_q == '0) begin
                    sel_result = DIV0_RESULT;
                    sel_div0   = 1'b1;
                end else begin
                    sel_result = {16'd0, bus_if.alu_div};
                end
            end
            OP_AND:  sel_result = {16'd0, bus_if.alu_and};
            OP_OR:   sel_result = {16'd0, bus_if.alu_or};
            OP_XOR:  sel_result = {16'd0, bus_if.alu_xor};
            OP_NOR:  sel_result = {16'd0, bus_if.alu_nor};
            default: sel_result = '0;
        endcase
    end

    // Zero flag is taken from the final (possibly forced) result
    always_comb begin
        push_entry.result = sel_result;
        push_entry.flags  = pack_flags(sel_div0, sel_neg, sel_carry, sel_result == '0);
    end

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .head_vld_o (head_vld),
        .head_dat_o (head_entry),
        .count_o    (fifo_count)
    );

    assign bus_if.out_valid  = head_vld;
    assign bus_if.out_result = head_entry.result;
    assign bus_if.out_flags  = head_entry.flags;

`ifdef ALU_DIV0_TRAP_EN
    logic err_div0_q, err_div0_d;

    // Sticky trap: set when a divide-by-zero result is pushed, cleared only by reset
    always_comb begin
        err_div0_d = err_div0_q | (push && push_entry.flags[FLAG_DIV0]);
    end

    // Trap register
    always_ff @(posedge clk) begin
        if (rst) begin
            err_div0_q <= 1'b0;
        end else begin
            err_div0_q <= err_div0_d;
        end
    end

    assign bus_if.err_div0 = err_div0_q;
`else
    assign bus_if.err_div0 = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed literal cases plus randomized traffic vs a queue model.
// Latency: model expects a result at the head 3 negedges after its accept decision, or right after its predecessor leaves.
// Backpressure: out_ready is held low or randomized to exercise FIFO fill and head stability.
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    localparam int DEPTH = 4;
`ifdef ALU_DIV0_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk;
    logic rst;
    alu_result_stage_if bus ();

    alu_result_stage #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External ALU behaviour; divide by zero returns junk the stage must ignore
    always_comb begin
        bus.alu_suma  = bus.alu_a + bus.alu_b;
        bus.alu_resta = bus.alu_a - bus.alu_b;
        bus.alu_mult  = bus.alu_a * bus.alu_b;
        bus.alu_div   = (bus.alu_b == 16'd0) ? 16'hDEAD : bus.alu_a / bus.alu_b;
        bus.alu_and   = bus.alu_a & bus.alu_b;
        bus.alu_or    = bus.alu_a | bus.alu_b;
        bus.alu_xor   = bus.alu_a ^ bus.alu_b;
        bus.alu_nor   = ~(bus.alu_a | bus.alu_b);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {div0,neg,carry,zero,result} straight from the opcode rules
    function automatic logic [35:0] expect_of(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        logic z, c, n, d;
        r = 32'd0; c = 1'b0; n = 1'b0; d = 1'b0;
        case (op)
            3'b000: begin r = a + b; c = r[16]; end
            3'b001: begin r = {16'h0, a - b}; c = (a < b); n = r[15]; end
            3'b010: begin r = a * b; n = r[31]; end
            3'b011: begin
                if (b == 16'd0) begin r = 32'h0000FFFF; d = 1'b1; end
                else r = {16'h0, a / b};
            end
            3'b100: r = {16'h0, a & b};
            3'b101: r = {16'h0, a | b};
            3'b110: r = {16'h0, a ^ b};
            default: r = {16'h0, ~(a | b)};
        endcase
        z = (r == 32'd0);
        return {d, n, c, z, r};
    endfunction

    typedef struct {
        logic [35:0] ent;
        int          t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_acc = 0;
    int   n_out = 0;
    bit   model_en = 1'b0;
    bit   err_model = 1'b0;
    bit   s0 = 1'b0;
    bit   s1 = 1'b0;
    bit   rand_on = 1'b0;

    // Reference model and per-cycle compare, all at the negedge
    initial begin
        bit err_vis;
        bit exp_vld;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (model_en) begin
                exp_vld = (q.size() > 0) && ((cyc - q[0].t) >= 3);
                chk("out_valid", bus.out_valid, exp_vld);
                if (bus.out_valid && q.size() > 0)
                    chk("head_entry", {bus.out_flags, bus.out_result}, q[0].ent);
                chk("in_ready", bus.in_ready, q.size() < DEPTH);
                err_vis = err_model | s1;
                chk("err_div0", bus.err_div0, TRAP ? err_vis : 1'b0);
                if (rst) begin
                    q.delete();
                    err_model = 1'b0; s0 = 1'b0; s1 = 1'b0;
                end else begin
                    if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                    err_model = err_vis;
                    s1 = s0;
                    s0 = 1'b0;
                    if (bus.in_valid && bus.in_ready) begin
                        e.ent = expect_of(bus.in_op, bus.in_a, bus.in_b);
                        e.t   = cyc;
                        q.push_back(e);
                        s0 = e.ent[35];
                        n_acc++;
                    end
                end
            end
        end
    end

    // Random consumer backpressure while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_on) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Hard stop in case something wedges
    initial begin
        #500000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) chk("issue_timeout", 1'b0, 1'b1);
    endtask

    task automatic directed(input string nm, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] exp_res, input logic [3:0] exp_fl);
        issue(op, a, b);
        @(negedge clk); chk({nm, "_lat1"}, bus.out_valid, 1'b0);
        @(negedge clk); chk({nm, "_lat2"}, bus.out_valid, 1'b0);
        @(negedge clk);
        chk({nm, "_valid"}, bus.out_valid, 1'b1);
        chk({nm, "_result"}, bus.out_result, exp_res);
        chk({nm, "_flags"}, bus.out_flags, exp_fl);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 400 && q.size() != 0; i++) step();
        chk({nm, "_drained"}, q.size() == 0, 1'b1);
    endtask

    initial begin
        int base;
        int took;
        logic [15:0] ra, rb;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_op = 3'd0;
        bus.in_a = 16'd0;
        bus.in_b = 16'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_alu_a", bus.alu_a, 16'd0);
        chk("rst_alu_b", bus.alu_b, 16'd0);
        chk("rst_err", bus.err_div0, 1'b0);
        step();
        rst = 1'b0;
        model_en = 1'b1;

        // Literal cases
        directed("suma", OP_SUMA, 16'hFFFF, 16'h0001, 32'h0001_0000, 4'b0010);
        step();
        directed("resta", OP_RESTA, 16'd3, 16'd5, 32'h0000_FFFE, 4'b0110);
        step();
        directed("mult", OP_MULT, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4'b0100);
        step();
        directed("and0", OP_AND, 16'hF0F0, 16'h0F0F, 32'h0000_0000, 4'b0001);
        step();
        directed("div0", OP_DIV, 16'd100, 16'd0, 32'h0000_FFFF, 4'b1000);
        chk("div0_err", bus.err_div0, TRAP);
        step();

        // Fill with consumer stalled: four accepted, fifth held, then all delivered in order
        bus.out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 5; i++) issue(OP_SUMA, 16'(i * 1000), 16'd7);
            end
            begin
                repeat (20) @(negedge clk);
                chk("fill_accepted", n_acc - base, 4);
                chk("fill_in_ready", bus.in_ready, 1'b0);
                step();
                bus.out_ready = 1'b1;
            end
        join
        drain("fill");
        chk("fill_delivered", n_out >= 5, 1'b1);

        // Back-to-back multiplies with a free-running consumer
        step();
        base = n_out;
        took = cyc;
        for (int i = 0; i < 8; i++) issue(OP_MULT, 16'hFFFF, (i % 2 == 0) ? 16'hFFFF : 16'(i));
        took = cyc - took;
        chk("b2b_rate", took <= 16, 1'b1);
        drain("b2b");
        chk("b2b_count", n_out - base, 8);

        // Reset with one op in flight and three queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(OP_XOR, 16'(i + 1), 16'h00FF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_out_valid", bus.out_valid, 1'b0);
        chk("rstmid_in_ready", bus.in_ready, 1'b1);
        chk("rstmid_alu_a", bus.alu_a, 16'd0);
        chk("rstmid_err", bus.err_div0, 1'b0);
        step();
        bus.out_ready = 1'b1;
        base = n_out;
        repeat (10) step();
        chk("rstmid_no_stale", n_out - base, 0);

        // Randomized traffic with random backpressure
        rand_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 16'd0;
                1: ra = 16'hFFFF;
                2: rb = 16'hFFFF;
                3: ra = rb;
                default: ;
            endcase
            issue(3'($urandom_range(0, 7)), ra, rb);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_on = 1'b0;
        bus.out_ready = 1'b1;
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set result FIFO entry count (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  stage can accept a request this cycle.
REQ-006 in_op  input  3  opcode: 000 suma, 001 resta, 010 mult, 011 div, 100 and, 101 or, 110 xor, 111 nor.
REQ-007 in_a / in_b  input  16 each  operands.
REQ-008 alu_a / alu_b  output  16 each  registered operands driven to the ALU.
REQ-009 alu_suma 17, alu_resta 16, alu_mult 32, alu_div 16, alu_and/or/xor/nor 16  inputs  combinational ALU results for alu_a/alu_b.
REQ-010 out_valid  output  1  result available at FIFO head.
REQ-011 out_ready  input  1  consumer accepts head.
REQ-012 out_result  output  32  selected result.
REQ-013 out_flags  output  4  {div0, neg, carry, zero}.
REQ-014 err_div0  output  1  sticky divide-by-zero indicator.

Function
REQ-015 Request SHALL be accepted when in_valid && in_ready; alu_a, alu_b and op SHALL be registered that edge with an in-flight bit set.
REQ-016 On the following edge the selected ALU result and flags SHALL be pushed into the FIFO and in-flight cleared; at most one op in flight.
REQ-017 Latency: accept at edge N -> out_valid high after edge N+2 when FIFO was empty.
REQ-018 in_ready SHALL equal (count + in_flight) < DEPTH; a FIFO pop in the same cycle SHALL NOT raise in_ready combinationally.
REQ-019 Result selection: suma zero-extended from 17 bits; mult full 32 bits; resta, div, and, or, xor, nor zero-extended from 16 bits.
REQ-020 zero SHALL be 1 when out_result == 0; neg SHALL be bit 15 of result for resta, bit 31 for mult, else 0.
REQ-021 carry SHALL be alu_suma[16] for suma, (alu_a < alu_b) borrow for resta, else 0.
REQ-022 div0 SHALL be 1 when op = div and alu_b == 0; result then SHALL be forced to 32'h0000FFFF regardless of ALU output.
REQ-023 FIFO pop SHALL occur when out_valid && out_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; push when full or pop when empty SHALL be impossible by construction.
REQ-025 out_result/out_flags SHALL be stable while out_valid && !out_ready.

Reset
REQ-026 On rst: count=0, pointers=0, in_flight=0, out_valid=0, in_ready=1, alu_a=alu_b=0, err_div0=0; FIFO contents need not clear.
REQ-027 rst mid-operation SHALL discard the in-flight op and all queued results; no push occurs on the reset edge.

Configuration
REQ-028 Macro ALU_DIV0_TRAP_EN defined: err_div0 SHALL set on the push edge of any div0 result and hold until rst.
REQ-029 Macro undefined: err_div0 SHALL be constant 0; div0 flag and forced result per REQ-022 remain.

Structure
REQ-030 Shared package SHALL hold opcode constants, flag bit indices, and DIV0_RESULT constant 32'h0000FFFF.
REQ-031 FIFO SHALL be a sub-module alu_result_fifo (parameter DEPTH, 36-bit data = result+flags, push/pop/count).
REQ-032 The ALU itself SHALL remain external; this block only drives operands and consumes its outputs.

Verification
REQ-033 op suma, A=16'hFFFF, B=16'h0001 -> out_result 32'h00010000, flags carry=1, zero=0, out_valid 2 cycles after accept.
REQ-034 op resta, A=3, B=5 -> out_result 32'h0000FFFE, carry=1, neg=1.
REQ-035 op div, A=100, B=0 -> out_result 32'h0000FFFF, div0=1; err_div0=1 with ALU_DIV0_TRAP_EN, 0 without.
REQ-036 out_ready=0, issue 5 ops with DEPTH=4 -> in_ready low after 4th accept (or earlier with in-flight), no loss; release out_ready -> 4 results in order, then 5th.
REQ-037 Continuous in_valid and out_ready with back-to-back ops (mult 16'hFFFF*16'hFFFF -> 32'hFFFE0001) -> throughput one result per 2 cycles max, order preserved.
REQ-038 Assert rst with 1 in-flight and 3 queued -> next cycle out_valid=0, in_ready=1, no stale result ever emitted.
